// File: rtl/traffic_display_drv.sv
// Two-digit multiplexed 7-segment driver and R/Y/G indicator for the traffic-light controller.
// Optional macro LAST3_BLINK_EN: countdown digits blink for the last 1..3 seconds of a colour.
module traffic_display_drv #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int BLINK_HZ = 2
) (
  input  logic       sys_clk,
  input  logic       sys_rst_p,
  input  logic [3:0] light_t,
  input  logic [2:0] light_ctrl,
  output logic [7:0] seg,
  output logic [1:0] dig_sel,
  output logic [2:0] led_rgb
);

  localparam int SCAN_DIV  = CLK_HZ / (2 * SCAN_HZ);
  localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  logic [6:0] s1, s2, s3;
  logic [3:0] cap_t;
  logic [2:0] cap_ctrl;

  // Capture only words that have been identical for two consecutive cycles, so torn updates are dropped.
  always_ff @(posedge sys_clk or posedge sys_rst_p) begin
    if (sys_rst_p) begin
      s1       <= '0;
      s2       <= '0;
      s3       <= '0;
      cap_t    <= '0;
      cap_ctrl <= '0;
    end else begin
      s1 <= {light_ctrl, light_t};
      s2 <= s1;
      s3 <= s2;
      if (s2 == s3) {cap_ctrl, cap_t} <= s2;
    end
  end

  logic [SCAN_W-1:0]  scan_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic               dig_idx;
  logic               blink_ph;

  always_ff @(posedge sys_clk or posedge sys_rst_p) begin
    if (sys_rst_p) begin
      scan_cnt  <= '0;
      blink_cnt <= '0;
      dig_idx   <= 1'b0;
      blink_ph  <= 1'b1;
    end else begin
      if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        dig_idx  <= ~dig_idx;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
        blink_cnt <= '0;
        blink_ph  <= ~blink_ph;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 8'hC0;
      4'd1:    seg_code = 8'hF9;
      4'd2:    seg_code = 8'hA4;
      4'd3:    seg_code = 8'hB0;
      4'd4:    seg_code = 8'h99;
      4'd5:    seg_code = 8'h92;
      4'd6:    seg_code = 8'h82;
      4'd7:    seg_code = 8'hF8;
      4'd8:    seg_code = 8'h80;
      4'd9:    seg_code = 8'h90;
      default: seg_code = SEG_BLANK;
    endcase
  endfunction

  logic       tens;
  logic [3:0] ones;
  logic [7:0] seg_nxt;
  logic [2:0] led_nxt;

  assign tens = (cap_t >= 4'd10);
  assign ones = tens ? (cap_t - 4'd10) : cap_t;

  always_comb begin
    seg_nxt = SEG_BLANK;
    led_nxt = 3'b000;
    case (cap_ctrl)
      3'b000: begin
        seg_nxt = SEG_BLANK;
        led_nxt = 3'b000;
      end
      3'b001, 3'b010, 3'b100: begin
        if (dig_idx) seg_nxt = tens ? seg_code(4'd1) : SEG_BLANK;
        else         seg_nxt = seg_code(ones);
        if (cap_ctrl == 3'b010) led_nxt = blink_ph ? 3'b010 : 3'b000;
        else                    led_nxt = cap_ctrl;
`ifdef LAST3_BLINK_EN
        if ((cap_t >= 4'd1) && (cap_t <= 4'd3) && !blink_ph) seg_nxt = SEG_BLANK;
`endif
      end
      default: begin
        seg_nxt = SEG_DASH;
        led_nxt = 3'b100;
      end
    endcase
  end

  // Digit enable and segment data share one register stage, so they switch on the same edge.
  always_ff @(posedge sys_clk or posedge sys_rst_p) begin
    if (sys_rst_p) begin
      seg     <= SEG_BLANK;
      dig_sel <= 2'b11;
      led_rgb <= 3'b000;
    end else begin
      seg     <= seg_nxt;
      dig_sel <= dig_idx ? 2'b01 : 2'b10;
      led_rgb <= led_nxt;
    end
  end

endmodule
